noc_injector: RTL and testbench

- Per-node network interface sitting directly upstream of one local port of the 4-node ring NoC.
- Accepts payload+destination from a processing element over a valid/ready handshake and formats flits.
- Buffers flits in a small queue and writes them into the router's local write port.
- Honours the router's full/almost_full backpressure, so no flit is lost or written into a full FIFO.

---
 rtl/noc_injector.sv | 122 ++++++++++++
 tb/tb_noc_injector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_injector.sv
// rtl/noc_injector.sv - ring NoC local-port injector: flit queue with full/almost_full throttling
// Optional macro NOC_INJECTOR_STATS_EN adds sent_cnt/stall_cnt outputs.
module noc_injector #(
  parameter int WIDTH   = 16,
  parameter int NODE_ID = 0,
  parameter int QDEPTH  = 4,
  parameter int QAW     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_dest,
  input  logic [WIDTH-3:0] in_payload,
  output logic             noc_write,
  output logic [WIDTH-1:0] noc_data,
  input  logic             noc_full,
  input  logic             noc_almost_full,
  output logic             drop,
  output logic [QAW:0]     q_count
`ifdef NOC_INJECTOR_STATS_EN
  ,
  output logic [15:0]      sent_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_SLOW    = 2'd2;
  localparam logic [1:0] ST_BLOCKED = 2'd3;

  localparam logic [QAW:0] DEPTH_C = (QAW+1)'(QDEPTH);
  localparam logic [1:0]   NODE_C  = 2'(NODE_ID);

  logic [WIDTH-1:0] mem_q [QDEPTH];
  logic [WIDTH-1:0] mem_d [QDEPTH];
  logic [QAW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [QAW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [QAW:0]     count_q, count_d;
  logic             noc_write_q, noc_write_d;
  logic [WIDTH-1:0] noc_data_q, noc_data_d;
  logic             drop_q, drop_d;
  logic [1:0]       state_q, state_d;
  logic             accept, push, pop;

  always_comb begin
    in_ready = (count_q < DEPTH_C);
    accept   = in_valid & in_ready;
    push     = accept & (in_dest != NODE_C);
    drop_d   = accept & (in_dest == NODE_C);
    // state_q is IDLE exactly when the queue is empty; the write-in-flight term enforces
    // the every-other-cycle rate while the router is almost full.
    pop      = (state_q != ST_IDLE) & ~noc_full & ~(noc_almost_full & noc_write_q);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {in_dest, in_payload};
    wr_ptr_d = push ? wr_ptr_q + QAW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + QAW'(1) : rd_ptr_q;
    count_d  = count_q + (QAW+1)'(push) - (QAW+1)'(pop);

    noc_write_d = pop;
    noc_data_d  = pop ? mem_q[rd_ptr_q] : noc_data_q;

    if (count_d == '0)        state_d = ST_IDLE;
    else if (noc_full)        state_d = ST_BLOCKED;
    else if (noc_almost_full) state_d = ST_SLOW;
    else                      state_d = ST_SEND;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      noc_write_q <= 1'b0;
      noc_data_q  <= '0;
      drop_q      <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      noc_write_q <= noc_write_d;
      noc_data_q  <= noc_data_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
    end
  end

  assign noc_write = noc_write_q;
  assign noc_data  = noc_data_q;
  assign drop      = drop_q;
  assign q_count   = count_q;

`ifdef NOC_INJECTOR_STATS_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // sent_cnt advances on the edge that raises noc_write, so it tracks the strobe it counts.
  always_comb begin
    sent_cnt_d  = sent_cnt_q + 16'(pop);
    stall_cnt_d = stall_cnt_q + 16'((state_q != ST_IDLE) & ~pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      sent_cnt_q  <= sent_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sent_cnt  = sent_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_noc_injector.sv
// tb/tb_noc_injector.sv - scoreboard bench for noc_injector: directed scenarios then random traffic
module tb_noc_injector;
  localparam int WIDTH   = 16;
  localparam int NODE_ID = 0;
  localparam int QDEPTH  = 4;
  localparam int QAW     = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_dest = 2'd0;
  logic [WIDTH-3:0] in_payload = '0;
  logic             noc_write;
  logic [WIDTH-1:0] noc_data;
  logic             noc_full = 1'b0;
  logic             noc_almost_full = 1'b0;
  logic             drop;
  logic [QAW:0]     q_count;

  noc_injector #(.WIDTH(WIDTH), .NODE_ID(NODE_ID), .QDEPTH(QDEPTH), .QAW(QAW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_payload(in_payload),
    .noc_write(noc_write), .noc_data(noc_data),
    .noc_full(noc_full), .noc_almost_full(noc_almost_full),
    .drop(drop), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a list of flits waiting to be written and the last-cycle write flag.
  logic [WIDTH-1:0] sb[$];
  int  m_cnt   = 0;
  bit  m_write = 0;
  bit  m_drop  = 0;
  int  wr_cycles[$];

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge reset) begin
    bit acc, pop;
    if (!reset) begin
      m_cnt = 0; m_write = 0; m_drop = 0;
      sb.delete();
    end else begin
      acc = in_valid && (m_cnt < QDEPTH);
      pop = (m_cnt > 0) && !noc_full && !(noc_almost_full && m_write);
      m_write = pop;
      m_drop  = acc && (in_dest == NODE_ID);
      if (pop) m_cnt--;
      if (acc && in_dest != NODE_ID) begin
        m_cnt++;
        sb.push_back({in_dest, in_payload});
      end
    end
  end

  always @(negedge clk) begin
    check("q_count", int'(q_count), m_cnt);
    check("in_ready", int'(in_ready), int'(m_cnt < QDEPTH));
    check("noc_write", int'(noc_write), int'(m_write));
    check("drop", int'(drop), int'(m_drop));
    if (noc_write) begin
      wr_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL noc_data: write with empty scoreboard, got 'h%0h (cycle %0d)", noc_data, cyc);
      end else begin
        check("noc_data", int'(noc_data), int'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] d, input logic [WIDTH-3:0] p);
    in_valid = v; in_dest = d; in_payload = p;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_noc_write", int'(noc_write), 0);
    check("rst_noc_data", int'(noc_data), 0);
    check("rst_q_count", int'(q_count), 0);
    check("rst_drop", int'(drop), 0);
    check("rst_in_ready", int'(in_ready), 1);
    reset = 1'b1;
    tick();

    // Single flit latency and formatting
    drive(1, 2'd2, 14'h0123);
    tick();
    drive(0, 2'd0, '0);
    check("single_q1", int'(q_count), 1);
    check("single_nowrite", int'(noc_write), 0);
    tick();
    check("single_write", int'(noc_write), 1);
    check("single_data", int'(noc_data), 16'h8123);
    check("single_q0", int'(q_count), 0);
    tick();
    check("single_pulse", int'(noc_write), 0);
    check("single_hold", int'(noc_data), 16'h8123);

    // Full router: 6 offered, 4 accepted, then drain back-to-back
    noc_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 2'(1 + i % 3), 14'(16'h0100 + i));
      tick();
    end
    drive(0, 2'd0, '0);
    check("full_q4", int'(q_count), 4);
    check("full_notready", int'(in_ready), 0);
    check("full_nowrite", int'(noc_write), 0);
    tick();
    wr_cycles.delete();
    noc_full = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("full_nwrites", wr_cycles.size(), 4);
    if (wr_cycles.size() == 4) check("full_span", wr_cycles[3] - wr_cycles[0], 3);
    check("full_ready_again", int'(in_ready), 1);

    // Almost full: alternating writes, 4 writes spanning 7 cycles
    noc_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'd3, 14'(16'h0a00 + i));
      tick();
    end
    drive(0, 2'd0, '0);
    wr_cycles.delete();
    noc_full = 1'b0;
    noc_almost_full = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    noc_almost_full = 1'b0;
    check("af_nwrites", wr_cycles.size(), 4);
    if (wr_cycles.size() == 4) check("af_span", wr_cycles[3] - wr_cycles[0], 6);

    // Self-addressed flit is dropped
    wr_cycles.delete();
    drive(1, 2'(NODE_ID), 14'h1555);
    tick();
    drive(0, 2'd0, '0);
    check("drop_pulse", int'(drop), 1);
    check("drop_q0", int'(q_count), 0);
    tick();
    check("drop_clear", int'(drop), 0);
    tick();
    check("drop_nowrite", wr_cycles.size(), 0);

    // Simultaneous push and pop at q_count=2
    noc_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 2'd1, 14'(16'h0200 + i));
      tick();
    end
    noc_full = 1'b0;
    wr_cycles.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'd2, 14'(16'h0300 + i));
      tick();
      check("pp_q2", int'(q_count), 2);
    end
    drive(0, 2'd0, '0);
    for (int i = 0; i < 4; i++) tick();
    check("pp_nwrites", wr_cycles.size(), 10);

    // Reset mid-drain with 3 queued
    noc_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'd1, 14'(16'h0400 + i));
      tick();
    end
    drive(0, 2'd0, '0);
    noc_full = 1'b0;
    @(posedge clk);
    #2;
    check("mid_write_active", int'(noc_write), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_write", int'(noc_write), 0);
    check("mid_rst_q", int'(q_count), 0);
    check("mid_rst_data", int'(noc_data), 0);
    tick();
    reset = 1'b1;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 14'($urandom));
      noc_full        = ($urandom_range(0, 99) < 15);
      noc_almost_full = ($urandom_range(0, 99) < 30);
      tick();
    end
    drive(0, 2'd0, '0);
    noc_full = 1'b0;
    noc_almost_full = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("final_empty", int'(q_count), 0);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
